// File: rtl/apb_arbiter_if.sv
// Bundled APB signals for the N-to-1 arbiter: upstream requester slots (apbs_*)
// and the single downstream port (apbm_*).
interface apb_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 16,
  parameter int W_DATA    = 32
);
  logic [N_MASTERS*W_ADDR-1:0] apbs_paddr;
  logic [N_MASTERS-1:0]        apbs_psel;
  logic [N_MASTERS-1:0]        apbs_penable;
  logic [N_MASTERS-1:0]        apbs_pwrite;
  logic [N_MASTERS*W_DATA-1:0] apbs_pwdata;
  logic [N_MASTERS*W_DATA-1:0] apbs_phartid;
  logic [N_MASTERS-1:0]        apbs_pready;
  logic [N_MASTERS*W_DATA-1:0] apbs_prdata;
  logic [N_MASTERS-1:0]        apbs_pslverr;

  logic [W_ADDR-1:0]           apbm_paddr;
  logic                        apbm_psel;
  logic                        apbm_penable;
  logic                        apbm_pwrite;
  logic [W_DATA-1:0]           apbm_pwdata;
  logic [W_DATA-1:0]           apbm_phartid;
  logic                        apbm_pready;
  logic [W_DATA-1:0]           apbm_prdata;
  logic                        apbm_pslverr;

  // slave: the arbiter itself (completer to requesters, initiator downstream)
  modport slave (
    input  apbs_paddr, apbs_psel, apbs_penable, apbs_pwrite, apbs_pwdata, apbs_phartid,
    output apbs_pready, apbs_prdata, apbs_pslverr,
    output apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata, apbm_phartid,
    input  apbm_pready, apbm_prdata, apbm_pslverr
  );

  // master: the environment around the arbiter (requesters plus downstream completer)
  modport master (
    output apbs_paddr, apbs_psel, apbs_penable, apbs_pwrite, apbs_pwdata, apbs_phartid,
    input  apbs_pready, apbs_prdata, apbs_pslverr,
    input  apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata, apbm_phartid,
    output apbm_pready, apbm_prdata, apbm_pslverr
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin N-to-1 APB arbiter: one grant held per transfer, clean SETUP/ACCESS
// downstream, losers stalled with pready low.
module apb_arbiter_lane #(
  parameter int W_DATA = 32
) (
  input  logic              hit,
  input  logic [W_DATA-1:0] rdata_in,
  input  logic              err_in,
  output logic              pready,
  output logic [W_DATA-1:0] prdata,
  output logic              pslverr
);
  assign pready  = hit;
  assign prdata  = hit ? rdata_in : '0;
  assign pslverr = hit & err_in;
endmodule

module apb_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 16,
  parameter int W_DATA    = 32
) (
  input logic         clk,
  input logic         rst,
  apb_arbiter_if.slave bus
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state;
  logic [GW-1:0]        gnt, last, nxt;
  logic                 any_req, dropped, psel_q, penable_q;
  logic [N_MASTERS-1:0] hit;
  logic                 unused_penable;

  // Requester penable carries no information the FSM needs.
  assign unused_penable = ^bus.apbs_penable;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_MASTERS) s -= N_MASTERS;
    return GW'(s);
  endfunction

  // Scan backwards so the slot nearest last+1 is the final (winning) assignment.
  always_comb begin
    nxt     = last;
    any_req = 1'b0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      if (bus.apbs_psel[rr_idx(last, k)]) begin
        nxt     = rr_idx(last, k);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= GW'(N_MASTERS - 1);
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dropped <= 1'b0;
          if (any_req) begin
            gnt    <= nxt;
            psel_q <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
          if (!bus.apbs_psel[gnt]) dropped <= 1'b1;
        end
        ACCESS: begin
          if (!bus.apbs_psel[gnt]) dropped <= 1'b1;
          if (bus.apbm_pready) begin
            last      <= gnt;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.apbm_psel    = psel_q;
  assign bus.apbm_penable = penable_q;
  assign bus.apbm_paddr   = bus.apbs_paddr[int'(gnt)*W_ADDR +: W_ADDR];
  assign bus.apbm_pwrite  = bus.apbs_pwrite[gnt];
  assign bus.apbm_pwdata  = bus.apbs_pwdata[int'(gnt)*W_DATA +: W_DATA];
  assign bus.apbm_phartid = bus.apbs_phartid[int'(gnt)*W_DATA +: W_DATA];

  // A requester that abandoned its transfer gets no response; the downstream side still completes.
  always_comb begin
    hit = '0;
    if (state == ACCESS && bus.apbm_pready && !dropped && bus.apbs_psel[gnt])
      hit[gnt] = 1'b1;
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    apb_arbiter_lane #(.W_DATA(W_DATA)) u_lane (
      .hit      (hit[i]),
      .rdata_in (bus.apbm_prdata),
      .err_in   (bus.apbm_pslverr),
      .pready   (bus.apbs_pready[i]),
      .prdata   (bus.apbs_prdata[i*W_DATA +: W_DATA]),
      .pslverr  (bus.apbs_pslverr[i])
    );
  end
endmodule
